fetch_queue: RTL
================

# fetch_queue

Parametrised instruction prefetch queue that replaces the single-word fetch stage in front of the pipeline. It owns its own fetch address, issues word reads to the bus interface while it has space, and buffers up to DEPTH fetched words with their addresses and bus-error flags. It presents them to the memory stage through a valid/ready handshake and flushes and restarts on a redirect from a jump or branch.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- ADDR_WIDTH, 30: word address width, matching the address[31:2] bus.
- DATA_WIDTH, 32: instruction word width.
- RESET_ADDRESS, 0: word address of the first fetch after reset.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately.
- redirect  in  1  flush the queue and restart fetching.
- redirect_address  in  ADDR_WIDTH  new fetch word address.
- mem_read  out  1  fetch request for mem_address.
- mem_address  out  ADDR_WIDTH  current fetch word address.
- mem_ready  in  1  the request completes this cycle; mem_data and mem_bus_error are valid.
- mem_data  in  DATA_WIDTH  fetched word.
- mem_bus_error  in  1  the fetch faulted.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- out_instruction  out  DATA_WIDTH  head word.
- out_address  out  ADDR_WIDTH  word address of the head word.
- out_fault  out  1  head word came from a faulted fetch.
- level  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a circular buffer with head and tail pointers of log2(DEPTH) bits, which wrap naturally, plus a count of 0..DEPTH.
- Each entry holds {fault, address, data}.
- `running` register:
  - cleared by reset.
  - set on the first clock edge after reset deasserts.
- `halted` register:
  - set when a faulted word is pushed.
  - cleared only by redirect or reset.
- mem_read = running & ~halted & ~redirect & (count != DEPTH).
- mem_read is not asserted on a full queue, even if a pop happens in the same cycle.
- Push occurs on mem_read & mem_ready:
  - the entry {mem_bus_error, fetch_pc, mem_data} is written at tail.
  - fetch_pc increments by 1, modulo 2^ADDR_WIDTH (wraps to 0).
- Pop occurs on out_valid & out_ready: head advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect has priority over everything else:
  - count, head and tail are cleared, halted is cleared, and fetch_pc loads redirect_address.
  - out_valid is forced low in the redirect cycle, so no pop occurs.
  - mem_read is low in that cycle, and no push occurs even if mem_ready is high.
- out_valid = (count != 0) & ~redirect.
- The head fields are driven from storage. Their values are don't-care when out_valid is low and must be stable while out_valid is high and out_ready is low.
- The consumer must not assume ordering across a redirect. All words from before the redirect are discarded.

## Timing
- Reset values:
  - mem_read 0, mem_address RESET_ADDRESS.
  - out_valid 0, out_fault 0, level 0.
  - out_instruction and out_address 0.
- The first request is asserted in the cycle after the first rising edge following reset release.
- With mem_ready held high and no stalls, one word is fetched per cycle.
- Latency without bypass: a word pushed at edge N is visible at the head from edge N onward, so out_valid is high in cycle N+1.
- After redirect at edge R, mem_read rises in cycle R+1 at redirect_address.
- Reset asserted mid-operation discards everything. Pending bus data is ignored.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - when count == 0 and a push occurs, the incoming word is presented on out_* in the same cycle, with out_valid high.
  - if out_ready is also high, the word is consumed and not stored; count stays 0.
  - a redirect still forces out_valid low.
- Not defined: there is no combinational path from mem_* to out_*, and the minimum latency is one cycle.

## Test plan
- Reset release, mem_ready=1, out_ready=1, RESET_ADDRESS=0x100 → out_address 0x100, 0x101, 0x102 on consecutive cycles. level stays 1 (0 with bypass).
- out_ready=0, DEPTH=4 → exactly 4 pushes, level=4, mem_read low. Then out_ready=1 for one cycle → level=3, and mem_read reasserts at address base+4.
- Redirect to 0x2000 with 3 entries queued and out_ready=1 → out_valid low that cycle, level=0 next cycle, next fetch at 0x2000, and no stale word is delivered.
- mem_bus_error=1 on the fetch at 0x10 → that entry is delivered with out_fault=1 and mem_read stays low. Redirect to 0x40 → fetching resumes with out_fault=0.
- fetch_pc=0x3FFFFFFF with ADDR_WIDTH=30 → next mem_address=0; with DEPTH=4, pointers wrap after 5+ pushes with data order intact.
- Reset pulled low while full with mem_ready=1 → all outputs return to reset values immediately, and the first request after release is at RESET_ADDRESS.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_queue                                                   |
// | Purpose  : Instruction prefetch queue. Owns the fetch address, issues    |
// |            word reads while it has space, buffers up to DEPTH fetched    |
// |            words with their address and bus-error flag, and hands them  |
// |            to the memory stage through a valid/ready handshake. A        |
// |            redirect flushes the queue and restarts fetching.             |
// | Ports    : clock, reset (async, active low)                              |
// |            redirect, redirect_address        - flush and new fetch pc    |
// |            mem_read, mem_address             - fetch request             |
// |            mem_ready, mem_data, mem_bus_error - fetch completion         |
// |            out_valid, out_ready              - head handshake            |
// |            out_instruction, out_address, out_fault - head entry fields   |
// |            level                             - occupied entries          |
// | Options  : FETCH_QUEUE_BYPASS_EN - present an incoming word on out_* in  |
// |            the cycle it arrives when the queue is empty.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int                    DEPTH         = 4,
  parameter int                    ADDR_WIDTH    = 30,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_address,
  output logic                         mem_read,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  input  logic                         mem_ready,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  input  logic                         mem_bus_error,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_instruction,
  output logic [ADDR_WIDTH-1:0]        out_address,
  output logic                         out_fault,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DEPTH-1:0]      r_fault;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_running;
  logic                  r_halted;

  logic w_empty;
  logic w_full;
  logic w_push;    // bus word accepted this cycle
  logic w_pop;     // consumer takes the presented word
  logic w_store;   // word is written into storage
  logic w_unload;  // stored head entry leaves storage

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);

  // A full queue never requests, even if a pop frees a slot this cycle;
  // this keeps the request free of any path from out_ready.
  assign mem_read    = r_running & ~r_halted & ~redirect & ~w_full;
  assign mem_address = r_fetch_pc;
  assign level       = r_count;

  assign w_push = mem_read & mem_ready;
  assign w_pop  = out_valid & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;

  // Empty queue: forward the arriving word straight to the consumer.
  assign w_bypass        = w_empty & w_push;
  assign out_valid       = (~w_empty | w_bypass) & ~redirect;
  assign out_instruction = w_bypass ? mem_data      : r_data[r_head];
  assign out_address     = w_bypass ? r_fetch_pc    : r_addr[r_head];
  assign out_fault       = w_bypass ? mem_bus_error : r_fault[r_head];
  // A forwarded word that is taken immediately never occupies a slot.
  assign w_store         = w_push & ~(w_bypass & out_ready);
  assign w_unload        = w_pop & ~w_empty;
`else
  assign out_valid       = ~w_empty & ~redirect;
  assign out_instruction = r_data[r_head];
  assign out_address     = r_addr[r_head];
  assign out_fault       = r_fault[r_head];
  assign w_store         = w_push;
  assign w_unload        = w_pop;
`endif

  // Control state: pointers, occupancy, fetch pc and run/halt flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_ADDRESS;
      r_running  <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_running <= 1'b1;
      if (redirect) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= redirect_address;
        r_halted   <= 1'b0;
      end else begin
        if (w_store) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_unload) begin
          r_head <= r_head + PTR_W'(1);
        end
        case ({w_store, w_unload})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
          // A faulted fetch stops further requests until a redirect.
          if (mem_bus_error) begin
            r_halted <= 1'b1;
          end
        end
      end
    end
  end

  // Entry storage. Cleared on reset so the head fields read zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
      end
      r_fault <= '0;
    end else if (w_store) begin
      r_data[r_tail]  <= mem_data;
      r_addr[r_tail]  <= r_fetch_pc;
      r_fault[r_tail] <= mem_bus_error;
    end
  end

endmodule
`default_nettype wire
